// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: default geometry, FSM states, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    localparam int DEPTH_DEF = 66;
    localparam int AW_DEF    = 7;
    localparam int NTAPS_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int CW_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    // Accumulator width: full product plus headroom for summing ntaps products.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Index width for a counter over n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_ring_addr_sub.sv
// Circular-buffer address: (base - offset) mod DEPTH, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
//
// Ports:
//   base   - newest-sample address, always < DEPTH
//   offset - tap index, always < DEPTH
//   addr   - address of the sample 'offset' positions older than base
module ring_addr_sub
#(
    parameter int DEPTH = 66,
    parameter int AW    = 7,
    parameter int KW    = 4
)(
    input  logic [AW-1:0] base,
    input  logic [KW-1:0] offset,
    output logic [AW-1:0] addr
);

    // One guard bit so DEPTH + base never overflows before the subtraction.
    logic [AW:0] base_w;
    logic [AW:0] offs_w;
    logic [AW:0] depth_w;

    always_comb begin
        base_w  = {1'b0, base};
        offs_w  = (AW+1)'(offset);
        depth_w = (AW+1)'(DEPTH);
        if (base_w >= offs_w) begin
            addr = AW'(base_w - offs_w);
        end else begin
            addr = AW'(base_w + depth_w - offs_w);
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR sequencer: per sample_en rising edge, write sample, read NTAPS history taps, MAC, emit y.
// Latency: y_valid NTAPS+3 cycles after the edge cycle; a new edge may land in the DONE cycle.
// Backpressure: none; edges arriving while busy are dropped and flagged on sticky overrun.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   sample_en, sample_in - sample request (rising edge acted on) and its data
//   wren/address_w/wdata - sample RAM write port
//   rden/address_r/rdata - sample RAM read port (rdata one cycle after rden)
//   coef_addr/coef_data  - coefficient ROM (coef_data one cycle after coef_addr)
//   y, y_valid           - filter result and its one-cycle strobe
//   busy                 - any state other than IDLE
//   overrun, overrun_clr - sticky dropped-sample flag and its clear
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int AW    = AW_DEF,
    parameter  int NTAPS = NTAPS_DEF,
    parameter  int DW    = DW_DEF,
    parameter  int CW    = CW_DEF,
    localparam int KW    = idx_width(NTAPS),
    localparam int ACCW  = acc_width(DW, CW, NTAPS)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_en,
    input  logic [DW-1:0]          sample_in,
    output logic                   wren,
    output logic [AW-1:0]          address_w,
    output logic [DW-1:0]          wdata,
    output logic                   rden,
    output logic [AW-1:0]          address_r,
    input  logic [DW-1:0]          rdata,
    output logic [KW-1:0]          coef_addr,
    input  logic [CW-1:0]          coef_data,
    output logic signed [ACCW-1:0] y,
    output logic                   y_valid,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    // fill saturates at NTAPS, so it needs to hold the value NTAPS itself.
    localparam int FW = $clog2(NTAPS + 1);
    localparam int PW = DW + CW;

    fsm_state_t state_q;
    fsm_state_t state_nx;

    logic                   sample_en_d;
    logic                   edge_det;
    logic                   accept;
    logic                   in_flight;
    logic                   tap_last;

    logic [AW-1:0]          wp;
    logic [AW-1:0]          waddr;
    logic [FW-1:0]          fill;
    logic [KW-1:0]          tap_k;

    // MAC stage runs one cycle behind the read that fetched its operands.
    logic                   mac_en;
    logic [KW-1:0]          mac_k;
    logic                   tap_live;

    logic signed [PW-1:0]   rd_ext;
    logic signed [PW-1:0]   cf_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_nx;

    assign edge_det  = sample_en & ~sample_en_d;
    assign accept    = edge_det & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign in_flight = (state_q == ST_WRITE) | (state_q == ST_READ) | (state_q == ST_DRAIN);
    assign tap_last  = (tap_k == KW'(NTAPS - 1));
    assign busy      = (state_q != ST_IDLE);
    assign coef_addr = tap_k;

    ring_addr_sub #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .KW    (KW)
    ) u_ring_addr (
        .base   (waddr),
        .offset (tap_k),
        .addr   (address_r)
    );

    // Explicit sign extension keeps the multiply at full product width.
    assign rd_ext   = {{CW{rdata[DW-1]}}, rdata};
    assign cf_ext   = {{DW{coef_data[CW-1]}}, coef_data};
    assign prod     = rd_ext * cf_ext;
    assign prod_ext = ACCW'(prod);

    // Taps reaching back past the first sample since reset hold stale RAM contents.
    assign tap_live = (FW'(mac_k) < fill);
    assign acc_nx   = acc + (tap_live ? prod_ext : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_READ;
            ST_READ:  if (tap_last) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_DONE;
            ST_DONE:  state_nx = accept ? ST_WRITE : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Tracking sample_en here hides a level that was already high across reset release.
            sample_en_d <= sample_en;
            wp          <= '0;
            waddr       <= '0;
            fill        <= '0;
            tap_k       <= '0;
            mac_en      <= 1'b0;
            mac_k       <= '0;
            acc         <= '0;
            wren        <= 1'b0;
            address_w   <= '0;
            wdata       <= '0;
            rden        <= 1'b0;
            y           <= '0;
            y_valid     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sample_en_d <= sample_en;

            // Strobes decode the next state so each is high exactly during its own state.
            wren    <= (state_nx == ST_WRITE);
            rden    <= (state_nx == ST_READ);
            y_valid <= (state_nx == ST_DONE);

            if (accept) begin
                address_w <= wp;
                wdata     <= sample_in;
            end

            if (state_q == ST_WRITE) begin
                waddr <= wp;
                wp    <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
                if (fill != FW'(NTAPS)) begin
                    fill <= fill + 1'b1;
                end
            end

            tap_k  <= ((state_q == ST_READ) && !tap_last) ? tap_k + 1'b1 : '0;
            mac_en <= (state_q == ST_READ);
            mac_k  <= tap_k;

            if (state_q == ST_WRITE) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc_nx;
            end

            // The final product lands during DRAIN; capture the completed sum for DONE.
            if (state_q == ST_DRAIN) begin
                y <= acc_nx;
            end

            if (edge_det && in_flight) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
